sysbus_mem_responder: RTL and testbench
=======================================

Name: sysbus_mem_responder

Overview:
- Memory-side responder on the Sysbus. Services the line-fill reads the core fetch path issues, plus line writes.
- Accepts one request at a time, acknowledges it, and returns a 64-byte line as 8 beats of 64 bits, beat 0 = lowest address.
- Backed by an internal line array. Sits opposite the core's bus initiator, in place of the DPI memory model, for standalone and integration benches.

Parameters:
- LINES, 1024, number of 64-byte lines in the backing array (power of two).
- LATENCY, 4, idle cycles between reqack and the first response beat (0 allowed).
- TAG_W, 13, width of reqtag/resptag.

Ports:
- clk  in  1  bus clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- reqcyc  in  1  request or write-data beat valid.
- req  in  64  request address (first cycle), then write-data beats.
- reqtag  in  TAG_W  {rw[12], kind[11:8], id[7:0]}; rw READ=1, WRITE=0; kind MEMORY=4'b0001.
- reqack  out  1  one-cycle acknowledge of a request or write beat.
- respcyc  out  1  response beat valid.
- resp  out  64  response data beat.
- resptag  out  TAG_W  copy of the accepted reqtag.
- respack  in  1  initiator accepts the current beat.

Behaviour:
- Reset: reqack=0, respcyc=0, resp=0, resptag=0; state=IDLE; beat and latency counters cleared. Array contents are not cleared.
- Reset mid-burst aborts immediately: respcyc drops the cycle after reset is sampled, and any partial write is kept in the array.
- States: IDLE, LAT, RESP, WDATA.
- IDLE, reqcyc=1, kind=MEMORY:
  - Latch line index = req[6+log2(LINES)-1:6] (upper bits ignored, so addresses wrap modulo the array). Latch reqtag.
  - Drive reqack=1 on the next cycle, for exactly one cycle.
  - rw=READ: go to LAT, or straight to RESP if LATENCY=0.
  - rw=WRITE: go to WDATA.
- IDLE, reqcyc=1, kind other than MEMORY: ignored; no reqack is issued.
- Address bits req[5:0] are ignored in the base configuration.
- LAT: count LATENCY cycles, then enter RESP.
- RESP:
  - respcyc=1; resp=line word[beat]; resptag=latched tag.
  - The beat advances on a posedge where respcyc & respack. Otherwise resp and resptag are held stable.
  - With respack tied high, the 8 beats are on consecutive cycles.
  - After beat 7 is accepted: respcyc=0 the next cycle, return to IDLE.
  - A new request can be sampled on the cycle after return, not earlier.
- WDATA:
  - Each cycle with reqcyc=1 writes req into word[beat] and pulses reqack for one cycle.
  - After the 8th word: return to IDLE. No response phase for writes.
  - Gaps (reqcyc=0) stall the beat counter.
- reqcyc while in LAT or RESP is ignored and not acked. The initiator must wait for the response.
- Read-after-write to the same line returns the newly written data.
- Beat counter is 3 bits; the line index is truncated to log2(LINES) bits.

Optional Feature:
- SYSBUS_CRITICAL_WORD_FIRST_EN
  - Defined: the read beat order starts at word req[5:3] and wraps modulo 8 (e.g. start 5 gives 5,6,7,0,1,2,3,4). Writes are unchanged.
  - Undefined: beats always start at word 0 and req[5:3] is ignored. This matches the core's aligned fetch with software skip.

Decomposition:
- Package sysbus_pkg:
  - tag field constants READ, WRITE, MEMORY, MMIO;
  - TAG_W;
  - line geometry constants (WORDS_PER_LINE=8, LINE_BYTES=64);
  - the state enum.
- Sub-module sysbus_mem_array holds the line storage:
  - one synchronous read port (line, word) with registered data;
  - one write port.
  - The responder must pre-issue the array read one cycle before the beat is presented, so resp stays stable under respack backpressure.

Test Plan:
- Directed reads (LATENCY=4):
  - Preload line 2 with words 0x1000+i. Read at req=0x80, respack=1 → reqack 1 cycle after reqcyc, first respcyc 4 cycles after reqack, 8 consecutive beats 0x1000..0x1007, resptag echoed.
  - Same read with respack low on beats 3 and 4 → beat 3 held for 3 cycles with resp unchanged, total burst 10 cycles.
- Directed write then read:
  - Write at 0x40 with data 0xA0..0xA7, reqcyc gap after word 2 → 8 reqack pulses, no respcyc.
  - Read 0x40 → 0xA0..0xA7.
- Wrap and tag filtering:
  - LINES=1024, read at 0x10080 → returns line 2 data.
  - Request with kind=MMIO → no reqack, stays IDLE.
- Reset mid-burst:
  - Assert reset during beat 4 → respcyc=0 the next cycle.
  - A new read afterwards completes with 8 correct beats.
- Critical word first (SYSBUS_CRITICAL_WORD_FIRST_EN defined): read at req=0x98 (word 3 of line 2) → beats 0x1003..0x1007, then 0x1000..0x1002.

Source files
------------

// File: rtl/sysbus_pkg.sv
// Shared Sysbus constants: tag fields, line geometry and the responder state encoding.
package sysbus_pkg;

   localparam int TAG_W          = 13;
   localparam int WORD_W         = 64;
   localparam int WORDS_PER_LINE = 8;
   localparam int LINE_BYTES     = 64;

   // reqtag = {rw, kind[3:0], id[7:0]}
   localparam int         RW_BIT = 12;
   localparam logic       READ   = 1'b1;
   localparam logic       WRITE  = 1'b0;
   localparam logic [3:0] MEMORY = 4'b0001;
   localparam logic [3:0] MMIO   = 4'b0010;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LAT   = 2'd1,
      RESP  = 2'd2,
      WDATA = 2'd3
   } state_t;

   function automatic logic [3:0] tag_kind(input logic [12:0] tag);
      return tag[11:8];
   endfunction

endpackage

// File: rtl/sysbus_mem_responder_if.sv
// Sysbus request/response signal bundle; master is the bus initiator, slave the memory side.
interface sysbus_mem_responder_if
   import sysbus_pkg::*;
#(
   parameter int TAG_W = sysbus_pkg::TAG_W
);
   logic              reqcyc;
   logic [WORD_W-1:0] req;
   logic [TAG_W-1:0]  reqtag;
   logic              reqack;
   logic              respcyc;
   logic [WORD_W-1:0] resp;
   logic [TAG_W-1:0]  resptag;
   logic              respack;

   modport master (
      output reqcyc, req, reqtag, respack,
      input  reqack, respcyc, resp, resptag
   );

   modport slave (
      input  reqcyc, req, reqtag, respack,
      output reqack, respcyc, resp, resptag
   );
endinterface

// File: rtl/sysbus_mem_array.sv
// Line storage: one write port and one read port with registered output data.
module sysbus_mem_array
   import sysbus_pkg::*;
#(
   parameter int LINES  = 1024,
   parameter int LINE_W = $clog2(LINES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_en,
   input  logic [LINE_W-1:0] rd_line,
   input  logic [2:0]        rd_word,
   output logic [WORD_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic [LINE_W-1:0] wr_line,
   input  logic [2:0]        wr_word,
   input  logic [WORD_W-1:0] wr_data
);
   localparam int DEPTH = LINES * WORDS_PER_LINE;

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[{wr_line, wr_word}] <= wr_data;
      end
   end

   // Read data only changes when rd_en is set, so it holds under backpressure.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[{rd_line, rd_word}];
      end
   end

endmodule

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory responder: serves 8-beat line reads and line writes from an internal array.
// Optional macro SYSBUS_CRITICAL_WORD_FIRST_EN starts read bursts at word req[5:3].
module sysbus_mem_responder
   import sysbus_pkg::*;
#(
   parameter int LINES   = 1024,
   parameter int LATENCY = 4,
   parameter int TAG_W   = sysbus_pkg::TAG_W
) (
   input logic                   clk,
   input logic                   reset,
   sysbus_mem_responder_if.slave bus
);
   localparam int LINE_W   = $clog2(LINES);
   localparam int LAT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int LAT_LAST = (LATENCY > 0) ? LATENCY - 1 : 0;

   state_t            state_reg;
   state_t            state_next;
   logic [LINE_W-1:0] line_reg;
   logic [TAG_W-1:0]  tag_reg;
   logic [2:0]        beat_reg;
   logic [2:0]        start_reg;
   logic [LAT_W-1:0]  lat_reg;
   logic              reqack_reg;
   logic              reqack_next;

   logic              accept;
   logic              is_read;
   logic              last_beat;
   logic [LINE_W-1:0] req_line;
   logic [2:0]        req_start;

   logic              respcyc;
   logic              rd_en;
   logic [LINE_W-1:0] rd_line;
   logic [2:0]        rd_word;
   logic [WORD_W-1:0] rd_data;
   logic              wr_en;

   assign req_line = bus.req[6 +: LINE_W];
`ifdef SYSBUS_CRITICAL_WORD_FIRST_EN
   assign req_start = bus.req[5:3];
`else
   assign req_start = 3'd0;
`endif

   logic unused_req;
   assign unused_req = ^{bus.req[WORD_W-1:6+LINE_W], bus.req[5:0]};

   assign accept    = (state_reg == IDLE) && bus.reqcyc && (tag_kind(bus.reqtag) == MEMORY);
   assign is_read   = (bus.reqtag[RW_BIT] == READ);
   assign last_beat = (beat_reg == 3'd7);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (!is_read) begin
                  state_next = WDATA;
               end else if (LATENCY == 0) begin
                  state_next = RESP;
               end else begin
                  state_next = LAT;
               end
            end
         end
         LAT: begin
            if (lat_reg == LAT_W'(LAT_LAST)) begin
               state_next = RESP;
            end
         end
         RESP: begin
            if (bus.respack && last_beat) begin
               state_next = IDLE;
            end
         end
         WDATA: begin
            if (bus.reqcyc && last_beat) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The array read for a beat is issued on the cycle before that beat is shown.
   always_comb begin
      respcyc     = (state_reg == RESP);
      reqack_next = accept || ((state_reg == WDATA) && bus.reqcyc);
      wr_en       = (state_reg == WDATA) && bus.reqcyc;
      rd_en       = (state_next == RESP) && ((state_reg != RESP) || bus.respack);
      rd_line     = (state_reg == IDLE) ? req_line : line_reg;
      rd_word     = (state_reg == IDLE) ? req_start : start_reg;
      if (state_reg == RESP) begin
         rd_word = start_reg + beat_reg + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         line_reg   <= '0;
         tag_reg    <= '0;
         beat_reg   <= '0;
         start_reg  <= '0;
         lat_reg    <= '0;
         reqack_reg <= 1'b0;
      end else begin
         reqack_reg <= reqack_next;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  line_reg  <= req_line;
                  tag_reg   <= bus.reqtag;
                  start_reg <= req_start;
                  beat_reg  <= '0;
                  lat_reg   <= '0;
               end
            end
            LAT: lat_reg <= lat_reg + LAT_W'(1);
            RESP: begin
               if (bus.respack) begin
                  beat_reg <= beat_reg + 3'd1;
               end
            end
            WDATA: begin
               if (bus.reqcyc) begin
                  beat_reg <= beat_reg + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   sysbus_mem_array #(
      .LINES  (LINES),
      .LINE_W (LINE_W)
   ) u_array (
      .clk     (clk),
      .reset   (reset),
      .rd_en   (rd_en),
      .rd_line (rd_line),
      .rd_word (rd_word),
      .rd_data (rd_data),
      .wr_en   (wr_en),
      .wr_line (line_reg),
      .wr_word (beat_reg),
      .wr_data (bus.req)
   );

   assign bus.reqack  = reqack_reg;
   assign bus.respcyc = respcyc;
   assign bus.resp    = respcyc ? rd_data : '0;
   assign bus.resptag = tag_reg;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Self-checking bench for sysbus_mem_responder: directed vector table, hand sequences, random traffic.
module tb_sysbus_mem_responder;
   import sysbus_pkg::*;

   localparam int LINES_P = 1024;
   localparam int LAT_P   = 4;
`ifdef SYSBUS_CRITICAL_WORD_FIRST_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   sysbus_mem_responder_if #(.TAG_W(13)) bus ();

   sysbus_mem_responder #(
      .LINES   (LINES_P),
      .LATENCY (LAT_P),
      .TAG_W   (13)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [63:0] addr;
      logic [7:0]  id;
      logic [31:0] stall;
      int          cycles;
      logic [63:0] first;
      bit          poke;
   } rd_vec_t;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] ref_mem [LINES_P][8];
   logic [63:0] wbuf [8];
   rd_vec_t     vecs [5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [12:0] mk_tag(input logic rw, input logic [3:0] kind, input logic [7:0] id);
      return {rw, kind, id};
   endfunction

   function automatic int burst_cycles(input logic [31:0] stall);
      int k = 0;
      int b = 0;
      while (b < 8) begin
         if (!(k < 32 && stall[k])) b++;
         k++;
      end
      return k;
   endfunction

   // Writes wbuf[0..nwords-1]; a short write ends with a reset to abort it.
   task automatic do_write(input logic [63:0] addr, input logic [7:0] id, input int gap, input int nwords);
      int line = int'(addr[15:6]);
      int racks = 0;
      int dacks = 0;
      int rseen = 0;
      bus.reqcyc = 1'b1;
      bus.req    = addr;
      bus.reqtag = mk_tag(WRITE, MEMORY, id);
      tick();
      if (bus.reqack) racks++;
      if (bus.respcyc) rseen++;
      for (int i = 0; i < nwords; i++) begin
         if (i == gap) begin
            bus.reqcyc = 1'b0;
            bus.req    = '0;
            tick();
            if (bus.reqack) dacks++;
            if (bus.respcyc) rseen++;
         end
         bus.reqcyc = 1'b1;
         bus.req    = wbuf[i];
         tick();
         if (bus.reqack) dacks++;
         if (bus.respcyc) rseen++;
         ref_mem[line][i] = wbuf[i];
      end
      bus.reqcyc = 1'b0;
      if (nwords < 8) begin
         reset = 1'b1;
         tick();
         reset = 1'b0;
      end else begin
         tick();
         if (bus.reqack) dacks++;
         if (bus.respcyc) rseen++;
      end
      check("wr_req_ack", 64'(racks), 64'd1);
      check("wr_data_acks", 64'(dacks), 64'(nwords));
      check("wr_no_resp", 64'(rseen), 64'd0);
   endtask

   task automatic do_read(input logic [63:0] addr, input logic [7:0] id, input logic [31:0] stall,
                          input int exp_cycles, input bit has_first, input logic [63:0] exp_first,
                          input bit poke, input int abort_beat);
      logic [12:0] tag = mk_tag(READ, MEMORY, id);
      int          line = int'(addr[15:6]);
      int          start = CWF ? int'(addr[5:3]) : 0;
      int          lat = 0;
      int          extra = 0;
      int          k = 0;
      int          b = 0;
      int          bad_hold = 0;
      int          bad_tag = 0;
      bit          stalled = 1'b0;
      bit          ack;
      logic [63:0] prev = '0;
      bus.reqcyc  = 1'b1;
      bus.req     = addr;
      bus.reqtag  = tag;
      bus.respack = 1'b0;
      tick();
      check("rd_req_ack", 64'(bus.reqack), 64'd1);
      if (poke) begin
         bus.req    = 64'h40;
         bus.reqtag = mk_tag(WRITE, MEMORY, 8'hEE);
      end else begin
         bus.reqcyc = 1'b0;
      end
      while (!bus.respcyc && lat < 64) begin
         tick();
         lat++;
         if (bus.reqack) extra++;
      end
      bus.reqcyc = 1'b0;
      check("rd_latency", 64'(lat), 64'(LAT_P));
      check("rd_ack_once", 64'(extra), 64'd0);
      while (b < 8 && k < 64) begin
         if (!bus.respcyc) break;
         if (bus.resptag !== tag) bad_tag++;
         if (stalled && bus.resp !== prev) bad_hold++;
         if (b == abort_beat) begin
            reset = 1'b1;
            bus.respack = 1'b1;
            tick();
            reset = 1'b0;
            bus.respack = 1'b0;
            check("abort_respcyc", 64'(bus.respcyc), 64'd0);
            check("abort_resp", bus.resp, 64'd0);
            check("abort_resptag", 64'(bus.resptag), 64'd0);
            check("abort_reqack", 64'(bus.reqack), 64'd0);
            return;
         end
         ack = !(k < 32 && stall[k]);
         bus.respack = ack;
         if (ack) begin
            check($sformatf("rd_beat%0d", b), bus.resp, ref_mem[line][(start + b) % 8]);
            if (b == 0 && has_first) check("rd_first", bus.resp, exp_first);
            b++;
         end
         stalled = !ack;
         prev = bus.resp;
         tick();
         k++;
      end
      bus.respack = 1'b0;
      check("rd_beats", 64'(b), 64'd8);
      check("rd_cycles", 64'(k), 64'(exp_cycles));
      check("rd_end", 64'(bus.respcyc), 64'd0);
      check("rd_tag", 64'(bad_tag), 64'd0);
      check("rd_hold", 64'(bad_hold), 64'd0);
   endtask

   task automatic do_ignored(input logic [3:0] kind);
      int acks = 0;
      int rseen = 0;
      bus.reqcyc = 1'b1;
      bus.req    = 64'h80;
      bus.reqtag = mk_tag(READ, kind, 8'h33);
      tick();
      bus.reqcyc = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (bus.reqack) acks++;
         if (bus.respcyc) rseen++;
         tick();
      end
      check("ign_ack", 64'(acks), 64'd0);
      check("ign_resp", 64'(rseen), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] addr;
      logic [31:0] stall;
      logic [3:0]  kind;
      int          op;
      int          line;
      int          gap;

      bus.reqcyc  = 1'b0;
      bus.req     = '0;
      bus.reqtag  = '0;
      bus.respack = 1'b0;
      reset       = 1'b1;
      repeat (3) tick();
      check("rst_reqack", 64'(bus.reqack), 64'd0);
      check("rst_respcyc", 64'(bus.respcyc), 64'd0);
      check("rst_resp", bus.resp, 64'd0);
      check("rst_resptag", 64'(bus.resptag), 64'd0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) wbuf[i] = 64'h1000 + 64'(i);
      do_write(64'h80, 8'h01, -1, 8);

      vecs[0] = '{addr: 64'h80,    id: 8'h10, stall: 32'h0,  cycles: 8,  first: 64'h1000, poke: 1'b0};
      vecs[1] = '{addr: 64'h80,    id: 8'h11, stall: 32'h18, cycles: 10, first: 64'h1000, poke: 1'b0};
      vecs[2] = '{addr: 64'h10080, id: 8'h12, stall: 32'h0,  cycles: 8,  first: 64'h1000, poke: 1'b0};
      vecs[3] = '{addr: 64'h98,    id: 8'h13, stall: 32'h0,  cycles: 8,
                  first: (CWF ? 64'h1003 : 64'h1000), poke: 1'b0};
      vecs[4] = '{addr: 64'h80,    id: 8'h14, stall: 32'h0,  cycles: 8,  first: 64'h1000, poke: 1'b1};
      for (int v = 0; v < 5; v++) begin
         do_read(vecs[v].addr, vecs[v].id, vecs[v].stall, vecs[v].cycles, 1'b1, vecs[v].first,
                 vecs[v].poke, -1);
      end

      // Write with a one-cycle gap after word 2, then read it back.
      for (int i = 0; i < 8; i++) wbuf[i] = 64'hA0 + 64'(i);
      do_write(64'h40, 8'h02, 3, 8);
      do_read(64'h40, 8'h20, 32'h0, 8, 1'b1, 64'hA0, 1'b0, -1);

      do_ignored(MMIO);
      do_read(64'h80, 8'h21, 32'h0, 8, 1'b1, 64'h1000, 1'b0, -1);

      // Reset during beat 4, then a clean read.
      do_read(64'h80, 8'h22, 32'h0, 8, 1'b0, 64'h0, 1'b0, 4);
      do_read(64'h80, 8'h23, 32'h0, 8, 1'b1, 64'h1000, 1'b0, -1);

      // Partial write aborted by reset keeps the words already written.
      for (int i = 0; i < 8; i++) wbuf[i] = 64'hB0 + 64'(i);
      do_write(64'h140, 8'h03, -1, 8);
      for (int i = 0; i < 8; i++) wbuf[i] = 64'hC0 + 64'(i);
      do_write(64'h140, 8'h04, -1, 3);
      do_read(64'h140, 8'h24, 32'h0, 8, 1'b1, 64'hC0, 1'b0, -1);

      for (int l = 0; l < 8; l++) begin
         for (int i = 0; i < 8; i++) wbuf[i] = {$urandom, $urandom};
         do_write(64'(l) << 6, 8'(l), -1, 8);
      end
      for (int t = 0; t < 40; t++) begin
         op   = int'($urandom_range(0, 9));
         line = int'($urandom_range(0, 7));
         addr = {$urandom, $urandom};
         addr[15:6] = 10'(line);
         if (op < 2) begin
            kind = 4'($urandom_range(0, 15));
            if (kind == MEMORY) kind = MMIO;
            do_ignored(kind);
         end else if (op < 5) begin
            for (int i = 0; i < 8; i++) wbuf[i] = {$urandom, $urandom};
            gap = int'($urandom_range(0, 8)) - 1;
            do_write(addr, 8'(t), gap, 8);
         end else begin
            stall = $urandom & $urandom;
            do_read(addr, 8'(t), stall, burst_cycles(stall), 1'b0, 64'h0, 1'b0, -1);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
